reservation_station: RTL

Unified reservation station sitting directly downstream of the dispatch bus. It reports free-entry availability and indices to dispatch, and accepts up to WIDTH renamed instructions per cycle. It tracks source-operand readiness via CDB tag broadcasts and selects up to ISSUE_WIDTH ready entries per cycle toward the functional units. Entries are freed on issue handshake or on squash.

---
 rtl/reservation_station.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Unified reservation station placed directly after the dispatch bus.
// - Reports up to WIDTH free entries (lowest index first) to dispatch and
//   accepts one renamed instruction per lane into the entry it was offered.
// - Tracks the two source operands of every entry.
//   Readiness comes from the map table, from tag 0, or from a CDB broadcast.
// - Selects up to ISSUE_WIDTH eligible entries (lowest index first) toward
//   the functional units. An entry is freed on the issue handshake or on
//   squash.
//
// Optional feature macro: RS_CDB_BYPASS_EN
//   When defined, eligibility also counts CDB tags matching in the current
//   cycle, so an entry can be woken and issued in the same cycle.
//
// Ports
//   clock_i          clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   avail_o          lane i has a free entry reserved for it
//   rs_idx_o         entry index reserved for lane i (packed per lane)
//   valid_i          lane i dispatches this cycle
//   payload_i        per-lane opaque payload
//   src_i            per-lane source tags, two per lane
//   ready_i          per-source ready bits from the map table
//   dst_i            per-lane destination tag
//   rob_idx_i        per-lane ROB index
//   lsq_idx_i        per-lane LSQ index
//   cdb_valid_i      CDB broadcast valid bits
//   cdb_tag_i        CDB broadcast tags
//   issue_valid_o    issue port k presents an entry
//   issue_ready_i    FU k accepts the presented entry
//   issue_*_o        stored fields of the entry on each issue port
//   free_count_o     number of invalid entries
//   squash_i         flush every entry
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int WIDTH        = 3,
    parameter int ENTRIES      = 16,
    parameter int ISSUE_WIDTH  = 3,
    parameter int CDB_WIDTH    = 3,
    parameter int PHY_REG_BITS = 6,
    parameter int ROB_IDX_BITS = 5,
    parameter int LSQ_IDX_BITS = 4,
    parameter int PAYLOAD_BITS = 64
) (
    input  logic                                  clock_i,
    input  logic                                  reset_n_i,
    output logic [WIDTH-1:0]                      avail_o,
    output logic [WIDTH*$clog2(ENTRIES)-1:0]      rs_idx_o,
    input  logic [WIDTH-1:0]                      valid_i,
    input  logic [WIDTH*PAYLOAD_BITS-1:0]         payload_i,
    input  logic [WIDTH*2*PHY_REG_BITS-1:0]       src_i,
    input  logic [WIDTH*2-1:0]                    ready_i,
    input  logic [WIDTH*PHY_REG_BITS-1:0]         dst_i,
    input  logic [WIDTH*ROB_IDX_BITS-1:0]         rob_idx_i,
    input  logic [WIDTH*LSQ_IDX_BITS-1:0]         lsq_idx_i,
    input  logic [CDB_WIDTH-1:0]                  cdb_valid_i,
    input  logic [CDB_WIDTH*PHY_REG_BITS-1:0]     cdb_tag_i,
    output logic [ISSUE_WIDTH-1:0]                issue_valid_o,
    input  logic [ISSUE_WIDTH-1:0]                issue_ready_i,
    output logic [ISSUE_WIDTH*PAYLOAD_BITS-1:0]   issue_payload_o,
    output logic [ISSUE_WIDTH*2*PHY_REG_BITS-1:0] issue_src_o,
    output logic [ISSUE_WIDTH*PHY_REG_BITS-1:0]   issue_dst_o,
    output logic [ISSUE_WIDTH*ROB_IDX_BITS-1:0]   issue_rob_idx_o,
    output logic [ISSUE_WIDTH*LSQ_IDX_BITS-1:0]   issue_lsq_idx_o,
    output logic [$clog2(ENTRIES):0]              free_count_o,
    input  logic                                  squash_i
);

    localparam int IW = $clog2(ENTRIES);
    localparam int P  = PHY_REG_BITS;

    // Entry state: valid/ready are reset, the data fields are not.
    logic [ENTRIES-1:0]      vld_q, vld_d;
    logic [1:0]              rdy_q [ENTRIES];
    logic [1:0]              rdy_d [ENTRIES];
    logic [P-1:0]            src_q [ENTRIES][2];
    logic [P-1:0]            dst_q [ENTRIES];
    logic [ROB_IDX_BITS-1:0] rob_q [ENTRIES];
    logic [LSQ_IDX_BITS-1:0] lsq_q [ENTRIES];
    logic [PAYLOAD_BITS-1:0] pay_q [ENTRIES];

    logic [WIDTH-1:0]        alloc_vld;
    logic [IW-1:0]           alloc_idx [WIDTH];
    logic [WIDTH-1:0]        disp_fire;
    logic [1:0]              lane_rdy  [WIDTH];
    logic [1:0]              wake      [ENTRIES];
    logic [ENTRIES-1:0]      elig;
    logic [ISSUE_WIDTH-1:0]  iss_vld;
    logic [IW-1:0]           iss_idx   [ISSUE_WIDTH];

    function automatic logic cdb_hit(input logic [P-1:0]           tag,
                                     input logic [CDB_WIDTH-1:0]   cv,
                                     input logic [CDB_WIDTH*P-1:0] ct);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cv[k] && (ct[k*P +: P] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Free-entry allocation: lane i takes the i-th lowest free entry.
    // It looks only at registered valid bits, so entries freed this cycle
    // are not offered until the next cycle.
    always_comb begin
        logic [ENTRIES-1:0] taken;
        taken     = '0;
        alloc_vld = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_idx[i] = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                if (!vld_q[e] && !taken[e] && !alloc_vld[i]) begin
                    alloc_vld[i] = 1'b1;
                    alloc_idx[i] = IW'(e);
                    taken[e]     = 1'b1;
                end
            end
        end
    end

    // Per-lane readiness at write time, including a same-cycle CDB capture.
    // Without this capture, a producer broadcasting in the dispatch cycle
    // would be missed forever.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign disp_fire[gi] = valid_i[gi] && alloc_vld[gi];
            for (genvar gj = 0; gj < 2; gj++) begin : g_src
                assign lane_rdy[gi][gj] = ready_i[gi*2+gj]
                    || (src_i[(gi*2+gj)*P +: P] == '0)
                    || cdb_hit(src_i[(gi*2+gj)*P +: P], cdb_valid_i, cdb_tag_i);
            end
        end
    endgenerate

    // Per-entry wakeup and eligibility.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_elig
            assign wake[gi][0] = cdb_hit(src_q[gi][0], cdb_valid_i, cdb_tag_i);
            assign wake[gi][1] = cdb_hit(src_q[gi][1], cdb_valid_i, cdb_tag_i);
`ifdef RS_CDB_BYPASS_EN
            assign elig[gi] = vld_q[gi] && ((rdy_q[gi] | wake[gi]) == 2'b11);
`else
            assign elig[gi] = vld_q[gi] && (rdy_q[gi] == 2'b11);
`endif
        end
    endgenerate

    // Issue select: port k takes the k-th lowest eligible entry.
    always_comb begin
        logic [ENTRIES-1:0] picked;
        picked  = '0;
        iss_vld = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            iss_idx[k] = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                if (elig[e] && !picked[e] && !iss_vld[k]) begin
                    iss_vld[k] = 1'b1;
                    iss_idx[k] = IW'(e);
                    picked[e]  = 1'b1;
                end
            end
        end
    end

    // Next state. Issue frees and dispatch writes never target the same entry,
    // because allocation only offers invalid entries. Squash overrides both.
    always_comb begin
        vld_d = vld_q;
        for (int e = 0; e < ENTRIES; e++) begin
            rdy_d[e] = rdy_q[e] | wake[e];
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (iss_vld[k] && issue_ready_i[k]) begin
                vld_d[iss_idx[k]] = 1'b0;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (disp_fire[i]) begin
                vld_d[alloc_idx[i]] = 1'b1;
                rdy_d[alloc_idx[i]] = lane_rdy[i];
            end
        end
        if (squash_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_q <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                rdy_q[e] <= 2'b00;
            end
        end else begin
            vld_q <= vld_d;
            for (int e = 0; e < ENTRIES; e++) begin
                rdy_q[e] <= rdy_d[e];
            end
        end
    end

    // Data fields are written by the dispatch lane that was offered the entry.
    always_ff @(posedge clock_i) begin
        for (int e = 0; e < ENTRIES; e++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (disp_fire[i] && (alloc_idx[i] == IW'(e))) begin
                    src_q[e][0] <= src_i[(i*2)*P +: P];
                    src_q[e][1] <= src_i[(i*2+1)*P +: P];
                    dst_q[e]    <= dst_i[i*P +: P];
                    rob_q[e]    <= rob_idx_i[i*ROB_IDX_BITS +: ROB_IDX_BITS];
                    lsq_q[e]    <= lsq_idx_i[i*LSQ_IDX_BITS +: LSQ_IDX_BITS];
                    pay_q[e]    <= payload_i[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                end
            end
        end
    end

    // Outputs
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alloc_out
            assign avail_o[gi]              = alloc_vld[gi];
            assign rs_idx_o[gi*IW +: IW]    = alloc_idx[gi];
        end
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_port
            assign issue_valid_o[gi] = iss_vld[gi];
            assign issue_payload_o[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = pay_q[iss_idx[gi]];
            assign issue_src_o[gi*2*P +: 2*P] = {src_q[iss_idx[gi]][1], src_q[iss_idx[gi]][0]};
            assign issue_dst_o[gi*P +: P]     = dst_q[iss_idx[gi]];
            assign issue_rob_idx_o[gi*ROB_IDX_BITS +: ROB_IDX_BITS] = rob_q[iss_idx[gi]];
            assign issue_lsq_idx_o[gi*LSQ_IDX_BITS +: LSQ_IDX_BITS] = lsq_q[iss_idx[gi]];
        end
    endgenerate

    always_comb begin
        free_count_o = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (!vld_q[e]) begin
                free_count_o = free_count_o + (IW+1)'(1);
            end
        end
    end

    // Dispatching on a lane that was not offered an entry is a protocol error.
    dispatch_on_unavail_lane : assert property (
        @(posedge clock_i) disable iff (!reset_n_i) ((valid_i & ~avail_o) == '0));

endmodule
